// File: rtl/demux1to4_capture_pkg.sv
// Shared definitions for the 4-lane mux/demux pair.
// Lane count, select width, capture FSM states and the one-hot select decoder.
package mux_pkg;
  localparam int unsigned LANES = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {IDLE, COLLECT} state_t;

  function automatic logic [LANES-1:0] onehot4(input logic [SEL_W-1:0] sel);
    logic [LANES-1:0] r;
    r      = '0;
    r[sel] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/demux1to4_capture_if.sv
// Lane-sample bus into the capture block and its parallel-word outputs.
// The master side sources the lane samples; the slave side is the capture block.
interface demux1to4_capture_if #(parameter int unsigned WIDTH = 1);
  import mux_pkg::*;

  logic [WIDTH-1:0]       In;
  logic [SEL_W-1:0]       sel;
  logic                   in_valid;
  logic [LANES*WIDTH-1:0] Out;
  logic [LANES*WIDTH-1:0] word;
  logic                   out_valid;
  logic                   err;

  modport master (output In, sel, in_valid, input Out, word, out_valid, err);
  modport slave  (input In, sel, in_valid, output Out, word, out_valid, err);
endinterface

// File: rtl/demux1to4_capture_lane_reg.sv
// One lane of the demux: WIDTH-bit register with async reset and load enable.
module lane_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end
endmodule

// File: rtl/demux1to4_capture.sv
// 1:4 lane demux with parallel-word reassembly, completion strobe and
// (in ordered mode) a sequence-violation strobe.
module demux1to4_capture
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter bit          ORDERED = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  demux1to4_capture_if.slave  bus
);
  logic [LANES-1:0]       lane_ld;
  logic [LANES*WIDTH-1:0] lanes;
  logic [LANES*WIDTH-1:0] merged;
  logic [LANES-1:0]       mask_next;
  logic [SEL_W-1:0]       exp_idx;
  logic [SEL_W-1:0]       want;
  logic [LANES-1:0]       lane_mask;
  state_t                 state;

  assign lane_ld = bus.in_valid ? onehot4(bus.sel) : '0;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_reg #(.WIDTH(WIDTH)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (lane_ld[i]),
      .d    (bus.In),
      .q    (lanes[i*WIDTH +: WIDTH])
    );
  end

  assign bus.Out = lanes;

  // The completing sample is still on In, so splice it into the stored lanes
  // to produce the word on the same edge rather than a cycle later.
  always_comb begin
    merged                          = lanes;
    merged[bus.sel*WIDTH +: WIDTH]  = bus.In;
  end

  assign mask_next = lane_mask | onehot4(bus.sel);
  assign want      = (state == IDLE) ? '0 : exp_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      exp_idx       <= '0;
      lane_mask     <= '0;
      bus.word      <= '0;
      bus.out_valid <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.err       <= 1'b0;
      if (bus.in_valid) begin
        if (ORDERED) begin
          if (bus.sel == want) begin
            if (want == SEL_W'(LANES-1)) begin
              bus.word      <= merged;
              bus.out_valid <= 1'b1;
              exp_idx       <= '0;
              state         <= IDLE;
            end else begin
              exp_idx <= want + SEL_W'(1);
              state   <= COLLECT;
            end
          end else begin
            bus.err <= 1'b1;
            if (bus.sel == '0) begin
              exp_idx <= SEL_W'(1);
              state   <= COLLECT;
            end else begin
              exp_idx <= '0;
              state   <= IDLE;
            end
          end
        end else begin
          if (mask_next == '1) begin
            bus.word      <= merged;
            bus.out_valid <= 1'b1;
            lane_mask     <= '0;
          end else begin
            lane_mask <= mask_next;
          end
        end
      end
    end
  end
endmodule
